// File: rtl/l2_request_responder_pkg.sv
// Shared encodings and types for the L2 request responder and the data cache.
package l2_request_responder_pkg;

    localparam int unsigned LINE_AW = 26;

    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_RWITM = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB,
        FILL,
        RESPOND
    } state_e;

    // One buffered request: command plus line address.
    typedef struct packed {
        logic [1:0]         cmd;
        logic [LINE_AW-1:0] addr;
    } req_t;

    localparam int unsigned REQ_W = $bits(req_t);

    // True for the two commands the responder services.
    function automatic logic is_valid_cmd(input logic [1:0] cmd);
        return (cmd == CMD_READ) || (cmd == CMD_RWITM);
    endfunction

endpackage

// File: rtl/req_fifo.sv
// Small request FIFO with registered full/empty flags.
module req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             full_q;
    logic             empty_q;
    logic             push_c;
    logic             pop_c;

    // A push is refused whenever the FIFO was full at this edge, pop or not.
    assign push_c = push_i && !full_q;
    assign pop_c  = pop_i && !empty_q;

    // Occupancy after this edge.
    always_comb begin
        count_d = count_q;
        if (push_c && !pop_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_c && pop_c) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointers, occupancy and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    // Storage; contents need no reset since empty gates every read.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign full_o     = full_q;
    assign empty_o    = empty_q;

endmodule

// File: rtl/l2_request_responder.sv
// L2-side responder: buffers cache requests and services them against a
// direct-mapped write-back tag store, using a req/ack memory port.
module l2_request_responder
    import l2_request_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned SETBITS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic [LINE_AW-1:0] add_in,
    input  logic [1:0]         cmd_in,
    output logic               full,
    output logic               mem_req,
    output logic               mem_we,
    output logic [LINE_AW-1:0] mem_addr,
    input  logic               mem_ack,
    output logic               rsp_valid,
    output logic [LINE_AW-1:0] rsp_addr,
    output logic               rsp_hit,
    output logic [31:0]        hit,
    output logic [31:0]        miss,
    output logic [31:0]        reads,
    output logic [31:0]        writes,
    output logic [31:0]        dropped
);

    localparam int unsigned TAG_W = LINE_AW - SETBITS;
    localparam int unsigned SETS  = 1 << SETBITS;

    state_e             state_q, state_d;
    req_t               work_q, work_d;
    req_t               push_req;
    req_t               fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               valid_cmd_c, push_c, drop_c, pop_c;

    logic               valid_q [SETS];
    logic               dirty_q [SETS];
    logic [TAG_W-1:0]   tag_q   [SETS];
    logic [SETBITS-1:0] idx_c;
    logic [TAG_W-1:0]   tag_c;
    logic               hit_c, set_dirty_c, install_c;

    logic               mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [LINE_AW-1:0] mem_addr_q, mem_addr_d, rsp_addr_q, rsp_addr_d;
    logic               rsp_valid_q, rsp_valid_d, rsp_hit_q, rsp_hit_d;
    logic [31:0]        hit_q, hit_d, miss_q, miss_d;
    logic [31:0]        reads_q, reads_d, writes_q, writes_d, dropped_q, dropped_d;

    // Request intake: only READ/RWITM count; a full FIFO drops the request.
    assign valid_cmd_c = req_valid && is_valid_cmd(cmd_in);
    assign push_c      = valid_cmd_c && !fifo_full;
    assign drop_c      = valid_cmd_c && fifo_full;
    assign push_req    = '{cmd: cmd_in, addr: add_in};

    req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REQ_W)
    ) u_req_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_c),
        .push_data_i (push_req),
        .pop_i       (pop_c),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Tag-store lookup for the request in the working register.
    assign idx_c = work_q.addr[SETBITS-1:0];
    assign tag_c = work_q.addr[LINE_AW-1:SETBITS];
    assign hit_c = valid_q[idx_c] && (tag_q[idx_c] == tag_c);

    // Intake statistics.
    always_comb begin
        reads_d   = reads_q;
        writes_d  = writes_q;
        dropped_d = dropped_q;
        if (push_c && (cmd_in == CMD_READ)) begin
            reads_d = reads_q + 32'd1;
        end
        if (push_c && (cmd_in == CMD_RWITM)) begin
            writes_d = writes_q + 32'd1;
        end
        if (drop_c) begin
            dropped_d = dropped_q + 32'd1;
        end
    end

    // Service FSM next state and registered outputs.
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        pop_c       = 1'b0;
        set_dirty_c = 1'b0;
        install_c   = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        rsp_valid_d = 1'b0;
        rsp_hit_d   = rsp_hit_q;
        rsp_addr_d  = rsp_addr_q;
        hit_d       = hit_q;
        miss_d      = miss_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop_c   = 1'b1;
                    work_d  = fifo_head;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit_c) begin
                    hit_d       = hit_q + 32'd1;
                    set_dirty_c = (work_q.cmd == CMD_RWITM);
                    rsp_valid_d = 1'b1;
                    rsp_hit_d   = 1'b1;
                    rsp_addr_d  = work_q.addr;
                    state_d     = RESPOND;
                end else begin
                    miss_d    = miss_q + 32'd1;
                    mem_req_d = 1'b1;
                    if (valid_q[idx_c] && dirty_q[idx_c]) begin
                        mem_we_d   = 1'b1;
                        mem_addr_d = {tag_q[idx_c], idx_c};
                        state_d    = WB;
                    end else begin
                        mem_we_d   = 1'b0;
                        mem_addr_d = work_q.addr;
                        state_d    = FILL;
                    end
                end
            end
            WB: begin
                // mem_req stays high; the next transaction is the fill.
                if (mem_ack) begin
                    mem_we_d   = 1'b0;
                    mem_addr_d = work_q.addr;
                    state_d    = FILL;
                end
            end
            FILL: begin
                if (mem_ack) begin
                    install_c   = 1'b1;
                    mem_req_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_hit_d   = 1'b0;
                    rsp_addr_d  = work_q.addr;
                    state_d     = RESPOND;
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, memory-port, response and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            work_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_addr_q  <= '0;
            hit_q       <= '0;
            miss_q      <= '0;
            reads_q     <= '0;
            writes_q    <= '0;
            dropped_q   <= '0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_addr_q  <= rsp_addr_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            reads_q     <= reads_d;
            writes_q    <= writes_d;
            dropped_q   <= dropped_d;
        end
    end

    // Per-set valid/dirty state; cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SETS; i++) begin
                valid_q[i] <= 1'b0;
                dirty_q[i] <= 1'b0;
            end
        end else begin
            if (set_dirty_c) begin
                dirty_q[idx_c] <= 1'b1;
            end
            if (install_c) begin
                valid_q[idx_c] <= 1'b1;
                dirty_q[idx_c] <= (work_q.cmd == CMD_RWITM);
            end
        end
    end

    // Tags are only meaningful behind a valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        if (install_c) begin
            tag_q[idx_c] <= tag_c;
        end
    end

    assign full      = fifo_full;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_hit   = rsp_hit_q;
    assign hit       = hit_q;
    assign miss      = miss_q;
    assign reads     = reads_q;
    assign writes    = writes_q;
    assign dropped   = dropped_q;

endmodule

// File: tb/tb_l2_request_responder.sv
// Scoreboard bench for l2_request_responder: directed scenarios plus random traffic.
module tb_l2_request_responder;
    import l2_request_responder_pkg::*;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned SETBITS = 8;
    localparam int unsigned SETS    = 1 << SETBITS;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [25:0] add_in;
    logic [1:0]  cmd_in;
    logic        full, mem_req, mem_we, mem_ack, rsp_valid, rsp_hit;
    logic [25:0] mem_addr, rsp_addr;
    logic [31:0] hit, miss, reads, writes, dropped;
    logic        man_ack, bfm_ack, auto_ack;

    assign mem_ack = auto_ack ? bfm_ack : man_ack;

    always #5 clk = ~clk;

    l2_request_responder #(.DEPTH(DEPTH), .SETBITS(SETBITS)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .add_in(add_in), .cmd_in(cmd_in),
        .full(full), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_hit(rsp_hit),
        .hit(hit), .miss(miss), .reads(reads), .writes(writes), .dropped(dropped)
    );

    typedef struct { logic [25:0] addr; logic hit; } rsp_t;
    typedef struct { logic we; logic [25:0] addr; } mem_t;

    rsp_t        exp_rsp[$];
    mem_t        exp_mem[$];
    bit          m_valid [SETS];
    bit          m_dirty [SETS];
    int unsigned m_tag   [SETS];
    int unsigned m_hit, m_miss, m_reads, m_writes, m_dropped;
    int unsigned checks = 0, errors = 0;
    int unsigned accepted = 0, rsp_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function void model_clear();
        for (int i = 0; i < int'(SETS); i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = 0;
        end
        m_hit = 0; m_miss = 0; m_reads = 0; m_writes = 0; m_dropped = 0;
    endfunction

    // Cache behaviour in service order: requests are serviced in acceptance order.
    function void model_service(input logic [1:0] cmd, input logic [25:0] addr);
        int unsigned a, idx, tg;
        bit h;
        a   = 32'(addr);
        idx = a % SETS;
        tg  = a / SETS;
        h   = m_valid[idx] && (m_tag[idx] == tg);
        if (cmd == CMD_READ) m_reads++; else m_writes++;
        if (h) begin
            m_hit++;
            if (cmd == CMD_RWITM) m_dirty[idx] = 1'b1;
        end else begin
            m_miss++;
            if (m_valid[idx] && m_dirty[idx])
                exp_mem.push_back('{1'b1, 26'(m_tag[idx] * SETS + idx)});
            exp_mem.push_back('{1'b0, addr});
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_dirty[idx] = (cmd == CMD_RWITM);
        end
        exp_rsp.push_back('{addr, h});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        cmd_in    = 2'($urandom);
        add_in    = 26'($urandom);
    endtask

    task automatic send(input logic [1:0] cmd, input logic [25:0] addr, input bit acc);
        if (acc) model_service(cmd, addr);
        else if (is_valid_cmd(cmd)) m_dropped++;
        req_valid = 1'b1;
        cmd_in    = cmd;
        add_in    = addr;
        tick();
    endtask

    task automatic do_reset(input int n);
        rst       = 1'b1;
        auto_ack  = 1'b0;
        man_ack   = 1'b0;
        idle();
        exp_rsp.delete();
        exp_mem.delete();
        model_clear();
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_hit"},     hit,     m_hit);
        check({tag, "_miss"},    miss,    m_miss);
        check({tag, "_reads"},   reads,   m_reads);
        check({tag, "_writes"},  writes,  m_writes);
        check({tag, "_dropped"}, dropped, m_dropped);
    endtask

    // Response monitor: every rsp_valid pulse must match the next expected response.
    initial begin : rsp_monitor
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                rsp_count++;
                check("rsp_expected", 32'(exp_rsp.size() > 0), 32'd1);
                if (exp_rsp.size() > 0) begin
                    e = exp_rsp.pop_front();
                    check("rsp_addr", 32'(rsp_addr), 32'(e.addr));
                    check("rsp_hit",  32'(rsp_hit),  32'(e.hit));
                end
            end
        end
    end

    // Memory responder for random traffic: checks each transaction, acks after a random delay.
    initial begin : mem_bfm
        mem_t e;
        bfm_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_ack && mem_req && !bfm_ack) begin
                check("mem_expected", 32'(exp_mem.size() > 0), 32'd1);
                if (exp_mem.size() > 0) begin
                    e = exp_mem.pop_front();
                    check("mem_we",   32'(mem_we),   32'(e.we));
                    check("mem_addr", 32'(mem_addr), 32'(e.addr));
                end
                repeat ($urandom_range(0, 3)) @(negedge clk);
                bfm_ack = 1'b1;
                @(negedge clk);
                bfm_ack = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin : main
        int n;
        int unsigned r, t, i2;
        logic [1:0]  cmd;
        logic [25:0] addr;
        rst = 1'b1; man_ack = 1'b0; auto_ack = 1'b0;
        idle();

        // Reset state
        do_reset(2);
        check("rst_full",      32'(full),      32'd0);
        check("rst_mem_req",   32'(mem_req),   32'd0);
        check("rst_mem_we",    32'(mem_we),    32'd0);
        check("rst_mem_addr",  32'(mem_addr),  32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_hit",   32'(rsp_hit),   32'd0);
        check("rst_rsp_addr",  32'(rsp_addr),  32'd0);
        check_counters("rst");

        // Clean miss, then hit on the same line
        send(CMD_READ, 26'h0000123, 1'b1); idle();      // cycle 0
        tick();                                          // cycle 1
        check("miss_mem_req_c1", 32'(mem_req), 32'd0);
        tick();                                          // cycle 2
        check("miss_mem_req",  32'(mem_req),  32'd1);
        check("miss_mem_we",   32'(mem_we),   32'd0);
        check("miss_mem_addr", 32'(mem_addr), 32'h123);
        tick(); tick(); man_ack = 1'b1; tick(); man_ack = 1'b0;   // cycle 5
        check("miss_rsp_valid", 32'(rsp_valid), 32'd1);
        check("miss_rsp_hit",   32'(rsp_hit),   32'd0);
        tick();
        check("miss_rsp_pulse", 32'(rsp_valid), 32'd0);
        check("miss_mem_done",  32'(mem_req),   32'd0);
        send(CMD_READ, 26'h0000123, 1'b1); idle();
        tick();
        check("hit_rsp_early", 32'(rsp_valid), 32'd0);
        tick();
        check("hit_rsp_valid", 32'(rsp_valid), 32'd1);
        check("hit_rsp_hit",   32'(rsp_hit),   32'd1);
        tick();
        check("hit_reads", reads, 32'd2);
        check("hit_hit",   hit,   32'd1);
        check("hit_miss",  miss,  32'd1);

        // Dirty eviction
        do_reset(1);
        send(CMD_RWITM, 26'h0000145, 1'b1); idle();
        tick(); tick();
        check("ev_fill1_we",   32'(mem_we),   32'd0);
        check("ev_fill1_addr", 32'(mem_addr), 32'h145);
        man_ack = 1'b1; tick(); man_ack = 1'b0;
        tick();
        send(CMD_RWITM, 26'h0000245, 1'b1); idle();
        tick(); tick();
        check("ev_wb_req",  32'(mem_req),  32'd1);
        check("ev_wb_we",   32'(mem_we),   32'd1);
        check("ev_wb_addr", 32'(mem_addr), 32'h145);
        man_ack = 1'b1; tick(); man_ack = 1'b0;
        check("ev_fill2_req",  32'(mem_req),  32'd1);
        check("ev_fill2_we",   32'(mem_we),   32'd0);
        check("ev_fill2_addr", 32'(mem_addr), 32'h245);
        man_ack = 1'b1; tick(); man_ack = 1'b0;
        tick();
        check("ev_writes", writes, 32'd2);
        check("ev_miss",   miss,   32'd2);

        // Overflow with memory stalled
        do_reset(1);
        for (int k = 0; k < 6; k++) begin
            send(CMD_READ, 26'(32'h10 + k), k < 5);
            if (k == 3) check("ovf_full_e3", 32'(full), 32'd0);
            if (k == 4) check("ovf_full_e4", 32'(full), 32'd1);
        end
        idle();
        check("ovf_full_e5",   32'(full),     32'd1);
        check("ovf_dropped",   dropped,       32'd1);
        check("ovf_reads",     reads,         32'd5);
        check("ovf_mem_addr",  32'(mem_addr), 32'h10);
        auto_ack = 1'b1;
        n = 0;
        while (exp_rsp.size() > 0 && n < 500) begin tick(); n++; end
        check("ovf_drain", 32'(exp_rsp.size()), 32'd0);
        tick(); tick();
        check("ovf_full_after", 32'(full), 32'd0);
        check_counters("ovf");

        // Reset in the middle of a fill
        do_reset(1);
        send(CMD_READ, 26'h0000077, 1'b1); idle();
        tick(); tick();
        check("rf_mem_req_before", 32'(mem_req), 32'd1);
        do_reset(1);
        check("rf_mem_req_after", 32'(mem_req), 32'd0);
        check("rf_reads", reads, 32'd0);
        check("rf_miss",  miss,  32'd0);
        man_ack = 1'b1; tick(); man_ack = 1'b0;
        check("rf_late_ack_req", 32'(mem_req),   32'd0);
        check("rf_late_ack_rsp", 32'(rsp_valid), 32'd0);
        send(CMD_READ, 26'h0000077, 1'b1); idle();
        tick(); tick();
        check("rf_refill_req",  32'(mem_req),  32'd1);
        check("rf_refill_addr", 32'(mem_addr), 32'h77);
        man_ack = 1'b1; tick(); man_ack = 1'b0;
        check("rf_refill_rsp", 32'(rsp_valid), 32'd1);
        check("rf_refill_hit", 32'(rsp_hit),   32'd0);
        tick();
        check("rf_miss_after", miss, 32'd1);

        // Ignored commands
        do_reset(1);
        send(2'b00, 26'h0000055, 1'b0);
        send(2'b11, 26'h0000066, 1'b0);
        idle();
        repeat (6) tick();
        check("ign_mem_req", 32'(mem_req), 32'd0);
        check("ign_full",    32'(full),    32'd0);
        check("ign_reads",   reads,        32'd0);
        check("ign_writes",  writes,       32'd0);
        check("ign_dropped", dropped,      32'd0);
        check("ign_miss",    miss,         32'd0);

        // Random traffic against the reference model
        do_reset(1);
        auto_ack = 1'b1;
        accepted = rsp_count;
        for (int it = 0; it < 400; it++) begin
            n = 0;
            while ((accepted - rsp_count) >= DEPTH && n < 200) begin
                idle(); tick(); n++;
            end
            if (n >= 200) check("rand_stall", accepted - rsp_count, DEPTH - 1);
            r = $urandom_range(0, 9);
            if (r == 0)     cmd = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
            else if (r < 5) cmd = CMD_READ;
            else            cmd = CMD_RWITM;
            if ($urandom_range(0, 3) == 0) begin
                addr = 26'($urandom);
            end else begin
                t    = $urandom_range(0, 3);
                i2   = $urandom_range(0, 3);
                addr = 26'(t * SETS + i2);
            end
            send(cmd, addr, is_valid_cmd(cmd));
            if (is_valid_cmd(cmd)) accepted++;
            repeat ($urandom_range(0, 2)) begin idle(); tick(); end
        end
        idle();
        n = 0;
        while (exp_rsp.size() > 0 && n < 3000) begin tick(); n++; end
        check("rand_drain_rsp", 32'(exp_rsp.size()), 32'd0);
        tick(); tick();
        check("rand_drain_mem", 32'(exp_mem.size()), 32'd0);
        check_counters("rand");
        auto_ack = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/l2_request_responder.md
# l2_request_responder

Next-level (L2-side) responder for the data cache's outbound request stream: accepts the 26-bit line address and 2-bit command the data cache issues, buffers them in a small FIFO, and services each against a direct-mapped, write-back tag store. Misses and dirty evictions go to a memory port with a req/ack handshake. Emits one response pulse per serviced request and keeps hit/miss/read/write/drop statistics for the statistics module.

## Interface
Parameters:
- DEPTH, 4, request FIFO entries; power of two, ≥2
- SETBITS, 8, index bits; tag width = 26−SETBITS

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  qualifies add_in/cmd_in; both are ignored when low (add_in may float to Z)
- add_in  in  26  line address (byte address [31:6])
- cmd_in  in  2  01 READ, 10 RWITM (write-allocate); 00 and 11 are ignored
- full  out  1  FIFO holds DEPTH entries
- mem_req  out  1  memory transaction pending
- mem_we  out  1  1 = writeback, 0 = fill
- mem_addr  out  26  line address of the memory transaction
- mem_ack  in  1  completes the current memory transaction when sampled high with mem_req
- rsp_valid  out  1  one-cycle response pulse
- rsp_addr  out  26  address of the serviced request
- rsp_hit  out  1  1 = tag-store hit
- hit, miss, reads, writes, dropped  out  32 each  statistics counters

## Operation
- Accept: req_valid && cmd_in∈{01,10} && !full → push {cmd, addr}. READ increments reads; RWITM increments writes.
- Drop: valid command while full → not enqueued, dropped++, reads/writes unchanged.
- cmd 00/11 with req_valid are ignored; no counter changes.
- Push and pop in the same cycle are legal. A push is rejected whenever full was high at that edge, even if a pop occurs on the same edge.
- Tag store per set: valid, dirty, tag. index = addr[SETBITS−1:0], tag = addr[25:SETBITS].
- FSM:
  - IDLE: if FIFO is non-empty, pop into the working register → LOOKUP.
  - LOOKUP (1 cycle):
    - Hit: hit++; RWITM sets dirty → RESPOND.
    - Miss: miss++. If the victim is valid && dirty → WB, else → FILL.
  - WB: mem_req=1, mem_we=1, mem_addr = {victim tag, index}. On ack → FILL.
  - FILL: mem_req=1, mem_we=0, mem_addr = request address. On ack, install tag, valid=1, dirty=(cmd==RWITM) → RESPOND.
  - RESPOND: rsp_valid=1, rsp_hit = value recorded in LOOKUP → IDLE.
- mem_req, mem_we and mem_addr hold stable until ack. mem_req stays high across the WB→FILL transition; each ack retires exactly one transaction.
- Counters wrap at 2^32.

## Timing
- Reset values:
  - all counters 0
  - full, mem_req, mem_we, rsp_valid, rsp_hit = 0
  - mem_addr, rsp_addr = 0
  - FIFO empty, all valid/dirty bits cleared, FSM in IDLE
- Reset takes priority over every other event, including a mid-transaction reset.
- Reset in WB/FILL abandons the transaction: mem_req is low in the cycle after the reset edge, and a late ack is ignored.
- Request sampled at edge k, FIFO empty, FSM idle:
  - pop at edge k+1, LOOKUP during cycle k+1
  - hit: rsp_valid high during cycle k+2
  - clean miss: mem_req high from cycle k+2; ack sampled at edge j → rsp_valid during cycle j
- full is registered: it reflects the count after each edge (count==DEPTH).
- Throughput for back-to-back hits: one response every 3 cycles.

## Structure
- Shared package holds:
  - command encodings CMD_READ=2'b01, CMD_RWITM=2'b10
  - line-address width 26
  - FSM state enum {IDLE, LOOKUP, WB, FILL, RESPOND}
- The data cache uses the same command constants from this package.
- Sub-module req_fifo (parameter DEPTH, width 28) provides push/pop/full/empty. The FSM and tag store stay in the top level.

## Test plan
- Reset: drive rst for 2 cycles → all outputs 0, full=0. Then READ 0x0000123 → no rsp_hit.
- Clean miss then hit:
  - READ 0x0000123 at edge 0 → mem_req=1, mem_we=0, mem_addr=0x0000123 from cycle 2.
  - ack at edge 5 → rsp_valid in cycle 5, rsp_hit=0.
  - Re-issue the READ → rsp_hit=1 two cycles after acceptance.
  - Counters: reads=2, hit=1, miss=1.
- Dirty eviction (SETBITS=8):
  - RWITM 0x0000145 (fill, acked) → dirty.
  - Then RWITM 0x0000245 → WB with mem_we=1, mem_addr=0x0000145; after that ack, FILL with mem_addr=0x0000245.
  - Counters: writes=2, miss=2.
- Overflow: hold mem_ack=0, issue READs 0x10..0x15 on edges 0–5.
  - 0x10 is popped at edge 1; 0x11–0x14 fill the FIFO; full=1 after edge 4.
  - 0x15 is dropped: dropped=1, reads=5.
- Reset mid-FILL: rst pulsed while mem_req=1 → mem_req=0 next cycle, counters 0. A subsequent READ of the same address misses.
- Ignored commands: req_valid with cmd_in=00 and with cmd_in=11 → no FIFO push, all counters unchanged, no rsp_valid.
